// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and sizing helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_t;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH + 1);

    function automatic int mdu_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the datapath and the multiply/divide unit.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_divstep.sv
// One restoring-division step on {remainder, quotient}; divisor is an unsigned magnitude.
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor holds between steps, so diff[WIDTH] is a clean borrow flag.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[WIDTH]) begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO. Define DIVIDER_EN to build the
// divide datapath; without it DIV/DIVU complete in one cycle and leave HI/LO alone.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// RUN   | one shift-add or restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction and HI/LO commit
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int CNT_W = mdu_cnt_w(WIDTH);
    localparam int W2    = 2 * WIDTH;

    mdu_state_t       state;
    logic [CNT_W-1:0] iter_cnt;
    logic [WIDTH-1:0] mag_a;
    logic             neg_res;
    logic [W2-1:0]    acc;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_nxt;
    logic [W2-1:0]    prod_fix;

    always_comb begin
        a_neg    = bus.op[0] & bus.a[WIDTH-1];
        b_neg    = bus.op[0] & bus.b[WIDTH-1];
        a_abs    = a_neg ? -bus.a : bus.a;
        b_abs    = b_neg ? -bus.b : bus.b;
        mul_add  = acc[0] ? mag_a : '0;
        mul_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, mul_add};
        mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
        prod_fix = neg_res ? -acc : acc;
    end

`ifdef DIVIDER_EN
    logic             div_q;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem     (acc[W2-1:WIDTH]),
        .quo     (acc[WIDTH-1:0]),
        .divisor (mag_b),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // A zero divisor leaves the dividend magnitude in the remainder, so only the
    // quotient needs overriding; the remainder sign fix restores the raw dividend.
    always_comb begin
        quo_fix = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix = neg_rem ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
            mag_a    <= '0;
            neg_res  <= 1'b0;
            acc      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef DIVIDER_EN
            div_q    <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            mag_b    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mthi) hi_q <= bus.wdata;
                    if (bus.mtlo) lo_q <= bus.wdata;
                    if (bus.start) begin
                        iter_cnt <= '0;
                        mag_a    <= a_abs;
                        neg_res  <= a_neg ^ b_neg;
`ifdef DIVIDER_EN
                        div_q    <= bus.op[1];
                        neg_rem  <= a_neg;
                        div_zero <= (bus.b == '0);
                        mag_b    <= b_abs;
                        acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
                        busy_q   <= 1'b1;
                        state    <= RUN;
`else
                        acc      <= {{WIDTH{1'b0}}, b_abs};
                        if (bus.op[1]) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end
`endif
                    end
                end
                RUN: begin
                    iter_cnt <= iter_cnt + CNT_W'(1);
`ifdef DIVIDER_EN
                    acc <= div_q ? {rem_nxt, quo_nxt} : mul_nxt;
`else
                    acc <= mul_nxt;
`endif
                    if (iter_cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
`ifdef DIVIDER_EN
                    if (div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[W2-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
`else
                    hi_q <= prod_fix[W2-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
`endif
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit; divide expectations follow the DIVIDER_EN build.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   lat;
    int   ndone;

    mdu_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
    endtask

    // Returns the cycle index (start-sampling edge = cycle 0) at which done is seen, 0 on timeout.
    task automatic wait_done(input int k0, output int l);
        l = 0;
        for (int k = k0; k <= 100; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
        bus.mthi  = 1'b1;
        bus.wdata = hv;
        @(posedge clk);
        #1;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b1;
        bus.wdata = lv;
        @(posedge clk);
        #1;
        bus.mtlo  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int l;
        issue(op, a, b);
        wait_done(1, l);
        check_val({tag, "_lat"}, l, exp_lat);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_hi"}, bus.hi, exp_hi);
        check_val({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
`ifdef DIVIDER_EN
        do_op(tag, op, a, b, 34, exp_hi, exp_lo);
`else
        mt_write(32'h0C0F_FEE0, 32'h0BAD_CAFE);
        do_op(tag, op, a, b, 1, 32'h0C0F_FEE0, 32'h0BAD_CAFE);
`endif
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = MDU_MULTU;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_hi", bus.hi, 0);
        check_val("rst_lo", bus.lo, 0);
        reset = 1'b0;
        @(negedge clk);

        do_op("multu_7x6", MDU_MULTU, 32'd7, 32'd6, 34, 32'h0, 32'd42);
        @(negedge clk);
        check_val("done_width", bus.done, 0);
        do_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_m3x5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op("mult_m4xm8", MDU_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 34, 32'h0, 32'd32);
        do_op("mult_minsq", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0);
        do_op("mult_maxxm1", MDU_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, 32'h8000_0001);

        mt_write(32'hAAAA_5555, 32'h1234_5678);
        check_val("mthi", bus.hi, 32'hAAAA_5555);
        check_val("mtlo", bus.lo, 32'h1234_5678);

        do_div("div_m7d2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_div("div_7dm2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        do_div("divu_100d7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        do_div("divu_100d0", MDU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        do_div("div_m8d0", MDU_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
        do_div("div_minm1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // back-to-back: second start lands in the done cycle of the first
        do_op("b2b_first", MDU_MULTU, 32'd3, 32'd4, 34, 32'h0, 32'd12);
        do_op("b2b_second", MDU_MULTU, 32'd5, 32'd5, 34, 32'h0, 32'd25);

        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000_1234;
        issue(MDU_MULTU, 32'd2, 32'd3);
        @(negedge clk);
        check_val("mthi_start_hi", bus.hi, 32'h0000_1234);
        check_val("mthi_start_busy", bus.busy, 1);
        wait_done(2, lat);
        check_val("mthi_start_lat", lat, 34);
        check_val("mthi_start_reshi", bus.hi, 32'h0);
        check_val("mthi_start_reslo", bus.lo, 32'd6);

        // start and mthi while busy are ignored, then reset aborts the operation
        mt_write(32'h0000_0BAD, 32'h0000_F00D);
        issue(MDU_MULTU, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_MULTU;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        @(negedge clk);
        check_val("busy_mthi_hi", bus.hi, 32'h0000_0BAD);
        check_val("busy_start_busy", bus.busy, 1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_done", bus.done, 0);
        check_val("abort_hi", bus.hi, 0);
        check_val("abort_lo", bus.lo, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check_val("abort_no_done", ndone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
